// File: rtl/ber_pkg.sv
// Shared definitions for the bit error tester (transmit and receive sides).
package ber_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEED = 2'd1,
        RUN  = 2'd2
    } ber_state_t;

    localparam logic PRBS_SEL_7  = 1'b0;
    localparam logic PRBS_SEL_15 = 1'b1;

    localparam logic [14:0] LFSR_SEED = 15'h7FFF;

    // Feedback taps: x^7+x^6+1 and x^15+x^14+1 on a left-shifting register.
    localparam int unsigned PRBS7_TAP_HI  = 6;
    localparam int unsigned PRBS7_TAP_LO  = 5;
    localparam int unsigned PRBS15_TAP_HI = 14;
    localparam int unsigned PRBS15_TAP_LO = 13;

    // Bits that take part in each polynomial, used by the lock-up guard.
    localparam logic [14:0] PRBS7_MASK  = 15'h007F;
    localparam logic [14:0] PRBS15_MASK = 15'h7FFF;

endpackage

// File: rtl/prbs_lfsr_core.sv
// 15-bit Fibonacci LFSR for PRBS-7 / PRBS-15 with seed load and lock-up guard.
// Shared between the transmitter and the receive checker.
module prbs_lfsr_core
    import ber_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic advance,
    input  logic sel,
    output logic fb
);

    logic [14:0] lfsr;
    logic        locked;

    // Tap mux and all-zero detection on the active polynomial bits
    always_comb begin
        fb     = 1'b0;
        locked = 1'b0;
        case (sel)
            PRBS_SEL_7: begin
                fb     = lfsr[PRBS7_TAP_HI] ^ lfsr[PRBS7_TAP_LO];
                locked = ((lfsr & PRBS7_MASK) == '0);
            end
            PRBS_SEL_15: begin
                fb     = lfsr[PRBS15_TAP_HI] ^ lfsr[PRBS15_TAP_LO];
                locked = ((lfsr & PRBS15_MASK) == '0);
            end
            default: begin
                fb     = 1'b0;
                locked = 1'b0;
            end
        endcase
    end

    // Shift register: seed on load, shift in feedback on advance
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr <= LFSR_SEED;
        end else if (load) begin
            lfsr <= LFSR_SEED;
        end else if (advance) begin
            lfsr <= locked ? LFSR_SEED : {lfsr[13:0], fb};
        end
    end

endmodule

// File: rtl/prbs_bit_transmitter.sv
// PRBS-7 / PRBS-15 transmitter with programmable bit period and bit counter.
// Optional error injection is enabled by defining BER_ERROR_INJECT_EN.
module prbs_bit_transmitter
    import ber_pkg::*;
#(
    parameter int unsigned div_width   = 16,
    parameter int unsigned count_width = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   prbs_sel,
    input  logic [div_width-1:0]   bit_period,
`ifdef BER_ERROR_INJECT_EN
    input  logic                   inject_error,
    output logic [count_width-1:0] errors_injected,
`endif
    output logic                   serial_out,
    output logic                   bit_strobe,
    output logic                   busy,
    output logic [count_width-1:0] bits_sent
);

    localparam logic [div_width-1:0]   DIV_ONE   = div_width'(1);
    localparam logic [count_width-1:0] COUNT_ONE = count_width'(1);

    ber_state_t           state;
    ber_state_t           state_next;
    logic                 sel_q;
    logic [div_width-1:0] period_q;
    logic [div_width-1:0] div_q;
    logic [div_width-1:0] period_eff;
    logic                 stop_pending;
    logic                 accept;
    logic                 boundary;
    logic                 finish;
    logic                 fb;
    logic                 tx_bit;
`ifdef BER_ERROR_INJECT_EN
    logic                 armed;
`endif

    // Next-state decode; a bit boundary is a RUN cycle with the divider at zero
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        boundary   = 1'b0;
        finish     = 1'b0;
        busy       = (state != IDLE);
        period_eff = (bit_period == '0) ? DIV_ONE : bit_period;
`ifdef BER_ERROR_INJECT_EN
        tx_bit     = fb ^ (armed | inject_error);
`else
        tx_bit     = fb;
`endif
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_next = SEED;
                    accept     = 1'b1;
                end
            end
            SEED: begin
                state_next = RUN;
            end
            RUN: begin
                if (div_q == '0) begin
                    if (stop || stop_pending) begin
                        finish     = 1'b1;
                        state_next = IDLE;
                    end else begin
                        boundary = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Configuration latch, bit divider, transmit register and bit counter.
    // The divider is zeroed at start so the first RUN cycle is a boundary,
    // giving the first bit two edges after start is sampled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel_q        <= PRBS_SEL_7;
            period_q     <= DIV_ONE;
            div_q        <= '0;
            stop_pending <= 1'b0;
            serial_out   <= 1'b0;
            bit_strobe   <= 1'b0;
            bits_sent    <= '0;
        end else begin
            bit_strobe <= boundary;
            if (accept) begin
                sel_q        <= prbs_sel;
                period_q     <= period_eff;
                div_q        <= '0;
                stop_pending <= 1'b0;
                serial_out   <= 1'b0;
                bits_sent    <= '0;
            end else if (finish) begin
                stop_pending <= 1'b0;
                serial_out   <= 1'b0;
            end else if (boundary) begin
                serial_out <= tx_bit;
                div_q      <= period_q - DIV_ONE;
                if (bits_sent != '1) begin
                    bits_sent <= bits_sent + COUNT_ONE;
                end
            end else if (state == RUN) begin
                div_q <= div_q - DIV_ONE;
                if (stop) begin
                    stop_pending <= 1'b1;
                end
            end
        end
    end

`ifdef BER_ERROR_INJECT_EN
    // Injection request flag and saturating count of inverted bits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            armed           <= 1'b0;
            errors_injected <= '0;
        end else if (accept) begin
            armed           <= 1'b0;
            errors_injected <= '0;
        end else if (finish) begin
            armed <= 1'b0;
        end else if (boundary) begin
            if (armed || inject_error) begin
                armed <= 1'b0;
                if (errors_injected != '1) begin
                    errors_injected <= errors_injected + COUNT_ONE;
                end
            end
        end else if (busy && inject_error) begin
            armed <= 1'b1;
        end
    end
`endif

    prbs_lfsr_core u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .load    (accept),
        .advance (boundary),
        .sel     (sel_q),
        .fb      (fb)
    );

endmodule

// File: tb/tb_prbs_bit_transmitter.sv
// Self-checking bench for prbs_bit_transmitter: timeline-based reference model
// plus directed literal checks and randomized runs.
module tb_prbs_bit_transmitter;

    localparam int unsigned DW      = 16;
    localparam int unsigned CW      = 32;
    localparam int unsigned SEQ_LEN = 4096;

    logic          clk        = 1'b0;
    logic          reset      = 1'b0;
    logic          start      = 1'b0;
    logic          stop       = 1'b0;
    logic          prbs_sel   = 1'b0;
    logic [DW-1:0] bit_period = '0;
    logic          serial_out;
    logic          bit_strobe;
    logic          busy;
    logic [CW-1:0] bits_sent;
`ifdef BER_ERROR_INJECT_EN
    logic          inject_error = 1'b0;
    logic [CW-1:0] errors_injected;
`endif

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    prbs_bit_transmitter #(
        .div_width   (DW),
        .count_width (CW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .stop            (stop),
        .prbs_sel        (prbs_sel),
        .bit_period      (bit_period),
`ifdef BER_ERROR_INJECT_EN
        .inject_error    (inject_error),
        .errors_injected (errors_injected),
`endif
        .serial_out      (serial_out),
        .bit_strobe      (bit_strobe),
        .busy            (busy),
        .bits_sent       (bits_sent)
    );

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference sequences from the recurrence s[n] = s[n-a] ^ s[n-b],
    // with every bit before the first one taken as 1 (all-ones seed).
    bit seq7  [SEQ_LEN];
    bit seq15 [SEQ_LEN];

    function automatic bit hist7(input int n);
        return (n < 0) ? 1'b1 : seq7[n];
    endfunction

    function automatic bit hist15(input int n);
        return (n < 0) ? 1'b1 : seq15[n];
    endfunction

    task automatic build_sequences();
        for (int n = 0; n < int'(SEQ_LEN); n++) begin
            seq7[n]  = hist7(n - 7) ^ hist7(n - 6);
            seq15[n] = hist15(n - 15) ^ hist15(n - 14);
        end
    endtask

    // Model: t counts edges since start was accepted (t=1 SEED, t=2 first RUN
    // cycle). Bit k is generated at edge t = 3 + k*P.
    bit          m_active = 1'b0;
    int unsigned m_t      = 0;
    int unsigned m_p      = 1;
    bit          m_sel    = 1'b0;
    bit          m_pend   = 1'b0;
    int unsigned m_final  = 0;
    bit          m_armed  = 1'b0;
    int unsigned m_err    = 0;
    bit          m_inv [SEQ_LEN];

    always @(posedge clk or negedge reset) begin : model
        int unsigned k;
        if (!reset) begin
            m_active = 1'b0;
            m_final  = 0;
            m_armed  = 1'b0;
            m_err    = 0;
        end else if (!m_active) begin
            if (start && !stop) begin
                m_active = 1'b1;
                m_t      = 1;
                m_p      = (bit_period == '0) ? 1 : int'(bit_period);
                m_sel    = prbs_sel;
                m_pend   = 1'b0;
                m_final  = 0;
                m_armed  = 1'b0;
                m_err    = 0;
                foreach (m_inv[i]) m_inv[i] = 1'b0;
            end
        end else begin
            m_t++;
            if (m_t >= 3 && stop) m_pend = 1'b1;
`ifdef BER_ERROR_INJECT_EN
            if (inject_error) m_armed = 1'b1;
`endif
            if (m_t >= 3 && ((m_t - 3) % m_p) == 0) begin
                k = (m_t - 3) / m_p;
                if (m_pend) begin
                    m_active = 1'b0;
                    m_final  = k;
                    m_armed  = 1'b0;
                end else if (m_armed) begin
                    if (k < SEQ_LEN) m_inv[k] = 1'b1;
                    m_armed = 1'b0;
                    m_err++;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin : compare
        bit              e_ser;
        bit              e_stb;
        bit              e_busy;
        longint unsigned e_bits;
        int unsigned     k;
        if (!m_active) begin
            e_ser = 1'b0; e_stb = 1'b0; e_busy = 1'b0; e_bits = m_final;
        end else if (m_t < 3) begin
            e_ser = 1'b0; e_stb = 1'b0; e_busy = 1'b1; e_bits = 0;
        end else begin
            k      = (m_t - 3) / m_p;
            e_ser  = (m_sel ? seq15[k % SEQ_LEN] : seq7[k % SEQ_LEN]) ^ m_inv[k % SEQ_LEN];
            e_stb  = (((m_t - 3) % m_p) == 0);
            e_busy = 1'b1;
            e_bits = k + 1;
        end
        check("serial_out", serial_out, e_ser);
        check("bit_strobe", bit_strobe, e_stb);
        check("busy", busy, e_busy);
        check("bits_sent", bits_sent, e_bits);
`ifdef BER_ERROR_INJECT_EN
        check("errors_injected", errors_injected, m_err);
`endif
    end

    // Driver-side capture of strobed bits and strobe spacing
    bit          cap[$];
    int unsigned cyc        = 0;
    int unsigned last_stb   = 0;
    int unsigned gap        = 0;

    task automatic step();
        @(negedge clk);
        cyc++;
        if (bit_strobe) begin
            cap.push_back(serial_out);
            gap      = cyc - last_stb;
            last_stb = cyc;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic wait_strobes(input int unsigned n, input int unsigned budget);
        for (int i = 0; i < int'(budget) && cap.size() < n; i++) step();
        check("strobe_wait", (cap.size() >= n) ? 1 : 0, 1);
    endtask

    task automatic wait_idle(input int unsigned budget);
        for (int i = 0; i < int'(budget) && busy; i++) step();
        check("idle_wait", busy, 0);
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : driver
        logic [6:0]  first7;
        logic [14:0] first15;
        int unsigned ncyc;
        build_sequences();

        // Reset state
        reset = 1'b0;
        repeat (3) step();
        check("reset_busy", busy, 0);
        check("reset_serial", serial_out, 0);
        check("reset_strobe", bit_strobe, 0);
        check("reset_bits", bits_sent, 0);
        reset = 1'b1;
        step();

        // PRBS-7, one clock per bit
        prbs_sel = 1'b0; bit_period = 1; cap.delete();
        pulse_start();
        wait_strobes(127, 400);
        check("prbs7_bits_127", bits_sent, 127);
        for (int i = 0; i < 7; i++) first7[6-i] = cap[i];
        check("prbs7_first7", first7, 7'b0000001);
        wait_strobes(260, 400);
        check("prbs7_gap", gap, 1);
        pulse_stop();
        wait_idle(50);

        // PRBS-15, four clocks per bit
        prbs_sel = 1'b1; bit_period = 4; cap.delete();
        pulse_start();
        wait_strobes(20, 200);
        for (int i = 0; i < 15; i++) first15[14-i] = cap[i];
        check("prbs15_first15", first15, 15'b000000000000001);
        check("prbs15_gap", gap, 4);
        pulse_stop();
        wait_idle(50);

        // bit_period of zero runs as one
        prbs_sel = 1'b0; bit_period = 0; cap.delete();
        pulse_start();
        wait_strobes(10, 100);
        check("period0_gap", gap, 1);
        pulse_stop();
        wait_idle(50);

        // start with stop in IDLE stays idle
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        step();
        check("start_stop_idle", busy, 0);

        // stop mid-bit completes the current bit
        prbs_sel = 1'b1; bit_period = 8; cap.delete();
        pulse_start();
        wait_strobes(3, 100);
        step(); step();
        pulse_stop();
        wait_idle(50);
        check("stop_bits", bits_sent, 3);
        check("stop_serial", serial_out, 0);
        repeat (5) step();
        check("stop_bits_retained", bits_sent, 3);

        // Asynchronous reset in the middle of a run
        prbs_sel = 1'b0; bit_period = 3; cap.delete();
        pulse_start();
        wait_strobes(5, 100);
        #2 reset = 1'b0;
        #1;
        check("midreset_busy", busy, 0);
        check("midreset_serial", serial_out, 0);
        check("midreset_strobe", bit_strobe, 0);
        check("midreset_bits", bits_sent, 0);
        step();
        reset = 1'b1;
        step();

`ifdef BER_ERROR_INJECT_EN
        // Single injected error
        prbs_sel = 1'b0; bit_period = 2; cap.delete();
        pulse_start();
        wait_strobes(10, 100);
        inject_error = 1'b1;
        step();
        inject_error = 1'b0;
        wait_strobes(16, 100);
        check("inject_bit11", cap[10], !seq7[10]);
        check("inject_bit12", cap[11], seq7[11]);
        check("inject_count", errors_injected, 1);
        pulse_stop();
        wait_idle(50);
`endif

        // Randomized runs
        for (int r = 0; r < 40; r++) begin
            repeat ($urandom_range(1, 4)) begin
                if ($urandom_range(0, 9) == 0) begin
                    start = 1'b1; stop = 1'b1;
                end
                step();
                start = 1'b0; stop = 1'b0;
            end
            prbs_sel   = $urandom_range(0, 1);
            bit_period = DW'($urandom_range(0, 6));
            pulse_start();
            ncyc = $urandom_range(5, 150);
            for (int c = 0; c < int'(ncyc); c++) begin
                if ($urandom_range(0, 99) < 3) start = 1'b1;
                if ($urandom_range(0, 99) < 3) begin
                    prbs_sel   = $urandom_range(0, 1);
                    bit_period = DW'($urandom_range(0, 9));
                end
`ifdef BER_ERROR_INJECT_EN
                inject_error = ($urandom_range(0, 99) < 2);
`endif
                step();
                start = 1'b0;
`ifdef BER_ERROR_INJECT_EN
                inject_error = 1'b0;
`endif
            end
            if ($urandom_range(0, 3) == 0) begin
                #2 reset = 1'b0;
                step();
                reset = 1'b1;
                step();
            end else begin
                pulse_stop();
                wait_idle(100);
            end
        end

        repeat (3) step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/prbs_bit_transmitter.md
Name: prbs_bit_transmitter

Overview:
- Transmit side of the bit error tester.
- Generates a PRBS-7 or PRBS-15 bit stream at a programmable bit period and drives it glitch-free from a register to the device under test.
- The receive side samples the returned stream through the input synchroniser and compares it against the same polynomial.
- Reports bit strobes and a transmitted-bit count for BER computation.

Parameters:
- div_width, 16, width of the bit_period input and the internal divider.
- count_width, 32, width of the bits_sent counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset: 0 resets, 1 runs.
- start  input  1  single-cycle request to begin transmission.
- stop  input  1  single-cycle request to end transmission at the next bit boundary.
- prbs_sel  input  1  0 = PRBS-7 (x^7+x^6+1), 1 = PRBS-15 (x^15+x^14+1); latched at start.
- bit_period  input  div_width  clocks per bit; latched at start; 0 is treated as 1.
- serial_out  output  1  registered transmit bit.
- bit_strobe  output  1  one-cycle pulse in the cycle a new bit first appears on serial_out.
- busy  output  1  high in SEED and RUN.
- bits_sent  output  count_width  bits presented since last start; saturates at all-ones.

Behaviour:
- Reset (reset=0, asynchronous):
  - state IDLE.
  - serial_out=0, bit_strobe=0, busy=0, bits_sent=0.
  - LFSR=all-ones, stop_pending=0.
- States: IDLE, SEED, RUN.
- IDLE:
  - serial_out held 0.
  - start=1 and stop=0 at an edge -> SEED.
  - start and stop together in IDLE -> stay IDLE (stop wins).
- SEED (one cycle):
  - Load 15-bit LFSR with all-ones; latch prbs_sel and max(bit_period,1).
  - Clear bits_sent; busy=1.
  - Next edge -> RUN and present the first bit.
- Bit generation at each bit boundary:
  - fb = lfsr[6]^lfsr[5] (PRBS-7) or lfsr[14]^lfsr[13] (PRBS-15).
  - lfsr <= {lfsr[13:0], fb}; serial_out <= fb.
  - bit_strobe=1 for that cycle; bits_sent increments, saturating.
- Latency: start sampled at edge N -> first bit on serial_out with bit_strobe after edge N+2.
- RUN timing:
  - Divider loads latched_period-1 on each new bit and decrements each cycle.
  - At 0 the next bit boundary occurs, so each bit is held exactly latched_period cycles.
  - With period 1, bit_strobe is continuously high.
- Stop:
  - stop in RUN sets stop_pending.
  - At the next bit boundary, no new bit is generated: state -> IDLE, serial_out=0, busy=0.
  - bits_sent retains its final value.
- start during SEED/RUN is ignored.
- Changes to prbs_sel/bit_period during RUN have no effect until the next start.
- Lock-up guard: if the active LFSR bits are ever all zero, reload all-ones at the next boundary. Unreachable from the seed; defensive only.
- Reset mid-run forces the reset values immediately, with no partial bit extension.
- Sequence lengths: PRBS-7 period 127 bits; PRBS-15 period 32767 bits.

Optional Feature:
- Macro: BER_ERROR_INJECT_EN.
- When defined:
  - Adds input inject_error (1 bit, single-cycle) and output errors_injected (count_width, saturating, cleared in SEED).
  - A pulse arms a flag; the next generated bit is driven inverted on serial_out and the flag clears.
  - The LFSR still shifts in the true fb, so the sequence is undisturbed and exactly one receive error results.
  - Pulses while armed are merged into a single injection.
  - A pulse in IDLE is ignored.
- When not defined: no extra ports; serial_out is always the true fb.

Decomposition:
- Shared package ber_pkg holds:
  - state encodings (IDLE/SEED/RUN).
  - PRBS select constants.
  - LFSR seed (15'h7FFF).
  - tap positions for PRBS-7/15, shared with the receive checker.
- Natural sub-module: prbs_lfsr_core, containing the LFSR register, tap mux, advance enable, seed load and lock-up guard. It is reusable by the receive checker.

Test Plan:
- Reset=0 mid-RUN at arbitrary cycle -> next sampled cycle serial_out=0, busy=0, bits_sent=0, bit_strobe=0.
- prbs_sel=0, bit_period=1, start -> first 7 bits 0,0,0,0,0,0,1; sequence repeats after exactly 127 strobes; bits_sent=127 after 127 bits.
- prbs_sel=1, bit_period=4, start -> each bit held 4 cycles, bit_strobe every 4th cycle, first 15 bits 14 zeros then 1, period 32767.
- bit_period=0 -> behaves identically to bit_period=1; start+stop same cycle in IDLE -> remains IDLE, busy=0.
- stop mid-bit with bit_period=8 -> current bit completes its 8 cycles, then IDLE with serial_out=0; bits_sent unchanged after stop.
- BER_ERROR_INJECT_EN: inject_error during bit 10 -> bit 11 inverted only, bits 12+ match reference PRBS, errors_injected=1.
